tx_source_arbiter: RTL and testbench

- Schedules the Ethernet transmit path between up to four packet sources (ARP reply, ICMP echo, UDP, spare), each built like the ARP reply generator: a one-cycle request pulse, then octets driven from a strobe.
- Latches pending requests and grants one source at a time by fixed priority.
- Drives the granted source's strobe for its packet length and muxes its octets onto one transmit stream.
- Pads short frames and enforces an inter-frame gap.

---
 rtl/tx_source_arbiter_pkg.sv | 25 ++
 rtl/tx_source_arbiter_prio_pick.sv | 36 +++
 rtl/tx_source_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_tx_source_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_source_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tx_source_arbiter_pkg
//   Shared constants for the transmit source arbiter: FSM state encoding,
//   well-known source slots, octet-length width and Ethernet minimum frame
//   length. Also a helper that sizes index buses safely for a single source.
// ----------------------------------------------------------------------------
package tx_source_arbiter_pkg;

   localparam int LEN_W       = 11;
   localparam int ETH_MIN_LEN = 60;

   localparam int SRC_ARP  = 0;
   localparam int SRC_ICMP = 1;
   localparam int SRC_UDP  = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_TAIL = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_source_arbiter_prio_pick.sv
// ----------------------------------------------------------------------------
// prio_pick
//   Combinational fixed-priority picker, lowest set index wins.
//   Ports:
//     req_vec  in   NSRC    candidate vector
//     pick_oh  out  NSRC    one-hot of the winner (0 when req_vec is 0)
//     pick_idx out  IDX_W   encoded index of the winner (0 when none)
//     pick_any out  1       req_vec has at least one bit set
// ----------------------------------------------------------------------------
module prio_pick
   import tx_source_arbiter_pkg::*;
#(
   parameter int NSRC  = 4,
   parameter int IDX_W = idx_width(NSRC)
) (
   input  logic [NSRC-1:0]  req_vec,
   output logic [NSRC-1:0]  pick_oh,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_any
);

   // Walk from the top down so the lowest set index is the last to overwrite.
   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_vec[i]) begin
            pick_oh    = '0;
            pick_oh[i] = 1'b1;
            pick_idx   = IDX_W'(i);
         end
      end
      pick_any = |req_vec;
   end

endmodule

// File: rtl/tx_source_arbiter.sv
// ----------------------------------------------------------------------------
// tx_source_arbiter
//   Shares one Ethernet transmit stream between NSRC packet generators.
//   Each generator is kicked by a one-cycle request and then supplies one
//   octet per strobe cycle, DATA_LAT cycles after the strobe. Requests are
//   latched, served one at a time by fixed priority (index 0 first), short
//   frames are zero-padded to MIN_LEN and an IFG idle gap follows each frame.
//
//   Ports:
//     clk       in   1          transmit clock
//     rst       in   1          asynchronous active-high reset
//     req       in   NSRC       per-source request pulse
//     len       in   11*NSRC    per-source length, source i at [11i+10:11i]
//     data_in   in   8*NSRC     per-source octet, source i at [8i+7:8i]
//     strobe    out  NSRC       one-hot octet-pull strobe to granted source
//     data_out  out  8          transmit octet (0 when tx_valid is low)
//     tx_valid  out  1          data_out valid
//     tx_last   out  1          final octet of the frame
//     busy      out  1          FSM not in IDLE
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | arbitrate pending requests; zero-length requests are discarded
//   SEND  | strobe the granted source for L cycles
//   TAIL  | drain the source pipeline and emit padding up to tx_last
//   GAP   | IFG idle cycles before arbitration resumes
// ----------------------------------------------------------------------------
module tx_source_arbiter
   import tx_source_arbiter_pkg::*;
#(
   parameter int NSRC     = 4,
   parameter int DATA_LAT = 2,
   parameter int MIN_LEN  = ETH_MIN_LEN,
   parameter int IFG      = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NSRC-1:0]         req,
   input  logic [LEN_W*NSRC-1:0]   len,
   input  logic [8*NSRC-1:0]       data_in,
   output logic [NSRC-1:0]         strobe,
   output logic [7:0]              data_out,
   output logic                    tx_valid,
   output logic                    tx_last,
   output logic                    busy
);

   localparam int                IDX_W     = idx_width(NSRC);
   localparam logic [LEN_W-1:0]  MIN_LEN_C = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0]  GAP_LAST  = LEN_W'(IFG - 1);

   logic [1:0]        state_q,    state_d;
   logic [NSRC-1:0]   pend_q,     pend_d;
   logic [IDX_W-1:0]  g_q,        g_d;
   logic [NSRC-1:0]   oh_q,       oh_d;
   logic [LEN_W-1:0]  len_q,      len_d;
   logic [LEN_W-1:0]  tot_q,      tot_d;
   logic [LEN_W-1:0]  scnt_q,     scnt_d;
   logic [LEN_W-1:0]  ocnt_q,     ocnt_d;
   logic [LEN_W-1:0]  gcnt_q,     gcnt_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              tx_valid_q, tx_valid_d;
   logic              tx_last_q,  tx_last_d;

   logic [LEN_W-1:0]  len_arr  [NSRC];
   logic [7:0]        data_arr [NSRC];

   logic [NSRC-1:0]   pick_oh;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [NSRC-1:0]   pend_clr;
   logic [LEN_W-1:0]  pick_len;
   logic              send_act;
   logic              src_v;
   logic              pad_v;

   for (genvar i = 0; i < NSRC; i++) begin : g_unpack
      assign len_arr[i]  = len[i*LEN_W +: LEN_W];
      assign data_arr[i] = data_in[i*8 +: 8];
   end

   prio_pick #(
      .NSRC  (NSRC),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_vec  (pend_q),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx),
      .pick_any (pick_any)
   );

   assign send_act = (state_q == ST_SEND);
   assign pick_len = len_arr[pick_idx];

   // src_v marks the cycle in which the granted source's octet for an
   // earlier strobe is present on data_in.
   if (DATA_LAT == 0) begin : g_lat0
      assign src_v = send_act;
   end else begin : g_latn
      logic [DATA_LAT-1:0] lat_q, lat_d;

      always_comb lat_d = DATA_LAT'({lat_q, send_act});

      always_ff @(posedge clk or posedge rst) begin
         if (rst) lat_q <= '0;
         else     lat_q <= lat_d;
      end

      assign src_v = lat_q[DATA_LAT-1];
   end

   always_comb begin
      state_d    = state_q;
      g_d        = g_q;
      oh_d       = oh_q;
      len_d      = len_q;
      tot_d      = tot_q;
      scnt_d     = scnt_q;
      ocnt_d     = ocnt_q;
      gcnt_d     = gcnt_q;
      pend_clr   = '0;

      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               pend_clr = pick_oh;
               if (pick_len != '0) begin
                  state_d = ST_SEND;
                  g_d     = pick_idx;
                  oh_d    = pick_oh;
                  len_d   = pick_len;
                  tot_d   = (pick_len > MIN_LEN_C) ? pick_len : MIN_LEN_C;
                  scnt_d  = '0;
                  ocnt_d  = '0;
               end
            end
         end
         ST_SEND: begin
            scnt_d = scnt_q + 11'd1;
            if (scnt_q == len_q - 11'd1) state_d = ST_TAIL;
         end
         ST_TAIL: begin
            if (tx_last_q) begin
               state_d = ST_GAP;
               gcnt_d  = '0;
            end
         end
         default: begin
            gcnt_d = gcnt_q + 11'd1;
            if (gcnt_q == GAP_LAST) state_d = ST_IDLE;
         end
      endcase

      // A request arriving with its own grant survives the clear.
      pend_d = (pend_q & ~pend_clr) | req;

      // Padding can only start once every source octet has been counted out,
      // so it follows the last data octet without a hole.
      pad_v      = (state_q == ST_TAIL) && !src_v &&
                   (ocnt_q >= len_q) && (ocnt_q < MIN_LEN_C);
      tx_valid_d = src_v | pad_v;
      data_out_d = src_v ? data_arr[g_q] : 8'h00;
      tx_last_d  = tx_valid_d && ((ocnt_q + 11'd1) == tot_q);
      if (tx_valid_d) ocnt_d = ocnt_q + 11'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         g_q        <= '0;
         oh_q       <= '0;
         len_q      <= '0;
         tot_q      <= '0;
         scnt_q     <= '0;
         ocnt_q     <= '0;
         gcnt_q     <= '0;
         data_out_q <= '0;
         tx_valid_q <= 1'b0;
         tx_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         g_q        <= g_d;
         oh_q       <= oh_d;
         len_q      <= len_d;
         tot_q      <= tot_d;
         scnt_q     <= scnt_d;
         ocnt_q     <= ocnt_d;
         gcnt_q     <= gcnt_d;
         data_out_q <= data_out_d;
         tx_valid_q <= tx_valid_d;
         tx_last_q  <= tx_last_d;
      end
   end

   assign strobe   = send_act ? oh_q : '0;
   assign data_out = data_out_q;
   assign tx_valid = tx_valid_q;
   assign tx_last  = tx_last_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_source_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tx_source_arbiter
//   Directed bench for tx_source_arbiter. A source model answers each strobe
//   with octet (64*i + k) two cycles later; a monitor records strobe runs and
//   emitted frames, which the directed sequences compare against hand-derived
//   lengths, timings and octet values.
// ----------------------------------------------------------------------------
module tb_tx_source_arbiter;
   import tx_source_arbiter_pkg::*;

   localparam int NSRC     = 4;
   localparam int DATA_LAT = 2;
   localparam int MIN_LEN  = 60;
   localparam int IFG      = 12;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NSRC-1:0]        req;
   logic [LEN_W*NSRC-1:0]  len;
   logic [8*NSRC-1:0]      data_in;
   logic [NSRC-1:0]        strobe;
   logic [7:0]             data_out;
   logic                   tx_valid;
   logic                   tx_last;
   logic                   busy;

   tx_source_arbiter #(
      .NSRC     (NSRC),
      .DATA_LAT (DATA_LAT),
      .MIN_LEN  (MIN_LEN),
      .IFG      (IFG)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .len      (len),
      .data_in  (data_in),
      .strobe   (strobe),
      .data_out (data_out),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // source model: octet k of source i is 64*i + k, DATA_LAT=2 after strobe
   logic [7:0] d1   [NSRC];
   int         scnt [NSRC];
   always @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (strobe[i]) begin
            d1[i]   <= 8'(i * 64 + scnt[i]);
            scnt[i] <= scnt[i] + 1;
         end else begin
            d1[i]   <= 8'h00;
            scnt[i] <= 0;
         end
         data_in[i*8 +: 8] <= d1[i];
      end
   end

   // monitor
   int              oi = 0, srun = 0, fcyc = 0, srise = 0, ssrc = 0;
   logic [NSRC-1:0] sprev = '0;
   int              frm_len[$], frm_first[$], frm_last[$], frm_base[$];
   logic [7:0]      octs[$];
   int              str_rise[$], str_src[$], str_len[$];
   int              gap_err = 0, dz_err = 0, mh_err = 0, busy_seen = 0;

   function automatic int oh2i(input logic [NSRC-1:0] v);
      int r = -1;
      for (int i = NSRC - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         oi    = 0;
         srun  = 0;
         sprev = '0;
      end else begin
         if (tx_valid) begin
            if (oi == 0) fcyc = cyc;
            octs.push_back(data_out);
            oi++;
            if (tx_last) begin
               frm_len.push_back(oi);
               frm_first.push_back(fcyc);
               frm_last.push_back(cyc);
               frm_base.push_back(octs.size() - oi);
               oi = 0;
            end
         end else begin
            if (oi != 0) gap_err++;
            if (data_out != 8'h00) dz_err++;
         end
         if ($countones(strobe) > 1) mh_err++;
         if (strobe != '0) begin
            if (sprev == '0) begin
               srise = cyc;
               ssrc  = oh2i(strobe);
               srun  = 0;
            end
            srun++;
         end else if (sprev != '0) begin
            str_rise.push_back(srise);
            str_src.push_back(ssrc);
            str_len.push_back(srun);
         end
         sprev = strobe;
         if (busy) busy_seen++;
      end
   end

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic int oct(input int f, input int k);
      if (f >= frm_len.size()) return -1;
      if (k >= frm_len[f]) return -1;
      return int'(octs[frm_base[f] + k]);
   endfunction

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_len(input int i, input int v);
      len[i*LEN_W +: LEN_W] = LEN_W'(v);
   endtask

   task automatic pulse(input logic [NSRC-1:0] v);
      @(posedge clk); #1 req = v;
      @(posedge clk); #1 req = '0;
   endtask

   task automatic run_wait(input int nfrm, input int budget, input string tag);
      int c = 0;
      while ((frm_len.size() < nfrm || busy) && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (c >= budget) chk({tag, "_timeout"}, c, 0);
      repeat (20) @(negedge clk);
   endtask

   int f0, s0, b0, c;

   initial begin
      rst = 1'b1;
      req = '0;
      len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_strobe",   int'(strobe),   0);
      chk("rst_tx_valid", int'(tx_valid), 0);
      chk("rst_tx_last",  int'(tx_last),  0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_busy",     int'(busy),     0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // single ARP, padded 42 -> 60
      f0 = frm_len.size(); s0 = str_len.size();
      set_len(SRC_ARP, 42);
      pulse(4'b0001);
      run_wait(f0 + 1, 500, "arp");
      chk("arp_frames",  frm_len.size() - f0, 1);
      chk("arp_strobes", str_len.size() - s0, 1);
      chk("arp_str_src", qat(str_src, s0), 0);
      chk("arp_str_len", qat(str_len, s0), 42);
      chk("arp_frm_len", qat(frm_len, f0), 60);
      chk("arp_latency", qat(frm_first, f0) - qat(str_rise, s0), DATA_LAT + 1);
      for (int k = 0; k < 60; k++)
         chk($sformatf("arp_oct%0d", k), oct(f0, k), (k < 42) ? k : 0);

      // simultaneous requests on sources 1 and 2
      f0 = frm_len.size(); s0 = str_len.size();
      set_len(SRC_ICMP, 70);
      set_len(SRC_UDP, 64);
      pulse(4'b0110);
      run_wait(f0 + 2, 1000, "sim");
      chk("sim_frames",   frm_len.size() - f0, 2);
      chk("sim_strobes",  str_len.size() - s0, 2);
      chk("sim_src0",     qat(str_src, s0), 1);
      chk("sim_src1",     qat(str_src, s0 + 1), 2);
      chk("sim_str_len0", qat(str_len, s0), 70);
      chk("sim_str_len1", qat(str_len, s0 + 1), 64);
      chk("sim_frm_len0", qat(frm_len, f0), 70);
      chk("sim_frm_len1", qat(frm_len, f0 + 1), 64);
      chk("sim_gap_str",  qat(str_rise, s0 + 1) - qat(frm_last, f0), IFG + 2);
      chk("sim_gap_tx",   qat(frm_first, f0 + 1) - qat(frm_last, f0), IFG + 2 + DATA_LAT + 1);
      chk("sim_oct_1_0",  oct(f0, 0), 64);
      chk("sim_oct_1_69", oct(f0, 69), 133);
      chk("sim_oct_2_0",  oct(f0 + 1, 0), 128);
      chk("sim_oct_2_63", oct(f0 + 1, 63), 191);
      chk("sim_idle",     int'(busy), 0);

      // source 0 re-requests while its own frame is being strobed
      f0 = frm_len.size(); s0 = str_len.size();
      set_len(SRC_ARP, 50);
      pulse(4'b0001);
      repeat (10) @(posedge clk);
      #1;
      chk("rereq_strobe", int'(strobe), 1);
      pulse(4'b0001);
      run_wait(f0 + 2, 1000, "rereq");
      chk("rereq_frames",  frm_len.size() - f0, 2);
      chk("rereq_strobes", str_len.size() - s0, 2);
      chk("rereq_src1",    qat(str_src, s0 + 1), 0);
      chk("rereq_str_len", qat(str_len, s0 + 1), 50);
      chk("rereq_frm_len", qat(frm_len, f0 + 1), 60);
      chk("rereq_gap_str", qat(str_rise, s0 + 1) - qat(frm_last, f0), IFG + 2);
      chk("rereq_oct49",   oct(f0 + 1, 49), 49);
      chk("rereq_oct50",   oct(f0 + 1, 50), 0);

      // request coincides with its own grant: pending bit must survive
      f0 = frm_len.size(); s0 = str_len.size();
      set_len(SRC_ARP, 10);
      @(posedge clk); #1 req = 4'b0001;
      repeat (2) @(posedge clk);
      #1 req = '0;
      run_wait(f0 + 2, 1000, "coll");
      chk("coll_frames",   frm_len.size() - f0, 2);
      chk("coll_strobes",  str_len.size() - s0, 2);
      chk("coll_str_len0", qat(str_len, s0), 10);
      chk("coll_str_len1", qat(str_len, s0 + 1), 10);
      chk("coll_frm_len1", qat(frm_len, f0 + 1), 60);
      chk("coll_gap_str",  qat(str_rise, s0 + 1) - qat(frm_last, f0), IFG + 2);

      // zero-length request is dropped and not retried
      f0 = frm_len.size(); s0 = str_len.size(); b0 = busy_seen;
      set_len(3, 0);
      pulse(4'b1000);
      repeat (10) @(negedge clk);
      chk("zero_strobes", str_len.size() - s0, 0);
      chk("zero_frames",  frm_len.size() - f0, 0);
      chk("zero_busy",    busy_seen - b0, 0);
      set_len(3, 5);
      repeat (20) @(negedge clk);
      chk("zero_no_retry", str_len.size() - s0, 0);
      chk("zero_no_busy",  busy_seen - b0, 0);
      chk("zero_strobe",   int'(strobe), 0);

      // reset at octet 20 of a 100-octet frame
      set_len(SRC_ARP, 100);
      pulse(4'b0001);
      c = 0;
      while (oi < 20 && c < 300) begin
         @(negedge clk);
         #2;
         c++;
      end
      if (c >= 300) chk("rst_mid_timeout", c, 0);
      chk("pre_rst_strobe", int'(strobe), 1);
      chk("pre_rst_valid",  int'(tx_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_strobe",   int'(strobe),   0);
      chk("mid_rst_tx_valid", int'(tx_valid), 0);
      chk("mid_rst_busy",     int'(busy),     0);
      chk("mid_rst_data_out", int'(data_out), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      f0 = frm_len.size(); s0 = str_len.size();
      set_len(SRC_ICMP, 30);
      pulse(4'b0010);
      run_wait(f0 + 1, 500, "post_rst");
      chk("post_rst_frames",  frm_len.size() - f0, 1);
      chk("post_rst_strobes", str_len.size() - s0, 1);
      chk("post_rst_src",     qat(str_src, s0), 1);
      chk("post_rst_str_len", qat(str_len, s0), 30);
      chk("post_rst_frm_len", qat(frm_len, f0), 60);
      chk("post_rst_oct0",    oct(f0, 0), 64);
      chk("post_rst_oct29",   oct(f0, 29), 93);
      chk("post_rst_oct30",   oct(f0, 30), 0);

      chk("inv_gap",      gap_err, 0);
      chk("inv_dataz",    dz_err,  0);
      chk("inv_multihot", mh_err,  0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
